// File: rtl/line_pingpong_reader_if.sv
// Pixel stream handshake from the line reader to the frame transport.
interface line_pingpong_reader_if;
  logic [15:0] rdData;
  logic        rdValid;
  logic        rdReady;
  logic        rdLast;
  logic        rdSof;

  modport master (
    output rdData,
    output rdValid,
    output rdLast,
    output rdSof,
    input  rdReady
  );

  modport slave (
    input  rdData,
    input  rdValid,
    input  rdLast,
    input  rdSof,
    output rdReady
  );
endinterface

// File: rtl/line_pingpong_reader.sv
// Ping-pong line store fed by the capture stage and
// drained as a valid/ready pixel stream.
module line_pingpong_reader #(
  parameter int LINE_PIX = 640,
  parameter int ADDR_W   = 10
) (
  input  logic              CamPCLK,
  input  logic              CamRSTn,
  input  logic              CamVSYNC,
  input  logic [15:0]       pixIn,
  input  logic              writeBuff1,
  input  logic              writeBuff2,
  input  logic              buffClear1,
  input  logic              buffClear2,
  input  logic              buffSelect,
  output logic [ADDR_W-1:0] lineCnt,
  output logic              overrun,
  output logic              overrunSticky,
  line_pingpong_reader_if.master rd
);

  localparam logic [ADDR_W-1:0] FULL_ADDR = ADDR_W'(LINE_PIX);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t state, stateNxt;

  logic [15:0] mem1 [LINE_PIX];
  logic [15:0] mem2 [LINE_PIX];

  logic [ADDR_W-1:0] wrAddr1, wrAddr2;
  logic [ADDR_W-1:0] len1, len2, lenNxt;
  logic [ADDR_W-1:0] rdAddr;
  logic [15:0]       rdData;
  logic full1, full2, fullNxt;
  logic nxt, buffSelD, commit1Q, commit2Q;
  logic sofArm, sofNow, lastPix;
  logic we1, we2, ovr1, ovr2, abort;
  logic accept, release1, release2;

  assign we1 = writeBuff1 && !buffClear1 && !CamVSYNC
               && (wrAddr1 != FULL_ADDR);
  assign we2 = writeBuff2 && !buffClear2 && !CamVSYNC
               && (wrAddr2 != FULL_ADDR);

  assign ovr1  = buffClear1 && full1 && !CamVSYNC;
  assign ovr2  = buffClear2 && full2 && !CamVSYNC;
  assign abort = nxt ? ovr2 : ovr1;

  assign lenNxt  = nxt ? len2 : len1;
  assign fullNxt = nxt ? full2 : full1;
  assign lastPix = (rdAddr == lenNxt - ONE);
  assign sofNow  = sofArm && (rdAddr == '0);

  assign accept = (state == OUT) && rd.rdReady
                  && !abort && !CamVSYNC;
  assign release1 = accept && lastPix && !nxt;
  assign release2 = accept && lastPix && nxt;

  assign rd.rdValid = (state == OUT);
  assign rd.rdLast  = (state == OUT) && lastPix;
  assign rd.rdSof   = (state == OUT) && sofNow;
  assign rd.rdData  = rdData;

  // Line storage: no reset, contents survive VSYNC.
  always_ff @(posedge CamPCLK) begin
    if (we1) mem1[wrAddr1] <= pixIn;
    if (we2) mem2[wrAddr2] <= pixIn;
  end

  always_ff @(posedge CamPCLK or negedge CamRSTn) begin
    if (!CamRSTn) begin
      wrAddr1  <= '0;
      wrAddr2  <= '0;
      buffSelD <= 1'b0;
      commit1Q <= 1'b0;
      commit2Q <= 1'b0;
    end else begin
      buffSelD <= buffSelect;
      commit1Q <= !CamVSYNC && buffSelect && !buffSelD;
      commit2Q <= !CamVSYNC && !buffSelect && buffSelD;
      if (CamVSYNC || buffClear1) wrAddr1 <= '0;
      else if (we1)               wrAddr1 <= wrAddr1 + ONE;
      if (CamVSYNC || buffClear2) wrAddr2 <= '0;
      else if (we2)               wrAddr2 <= wrAddr2 + ONE;
    end
  end

  // A zero-length commit leaves the buffer empty.
  always_ff @(posedge CamPCLK or negedge CamRSTn) begin
    if (!CamRSTn) begin
      full1 <= 1'b0;
      full2 <= 1'b0;
      len1  <= '0;
      len2  <= '0;
    end else if (CamVSYNC) begin
      full1 <= 1'b0;
      full2 <= 1'b0;
    end else begin
      if (ovr1 || release1) begin
        full1 <= 1'b0;
      end else if (commit1Q && wrAddr1 != '0) begin
        full1 <= 1'b1;
        len1  <= wrAddr1;
      end
      if (ovr2 || release2) begin
        full2 <= 1'b0;
      end else if (commit2Q && wrAddr2 != '0) begin
        full2 <= 1'b1;
        len2  <= wrAddr2;
      end
    end
  end

  always_ff @(posedge CamPCLK or negedge CamRSTn) begin
    if (!CamRSTn) begin
      overrun       <= 1'b0;
      overrunSticky <= 1'b0;
    end else if (CamVSYNC) begin
      overrun       <= 1'b0;
      overrunSticky <= 1'b0;
    end else begin
      overrun <= ovr1 || ovr2;
      if (ovr1 || ovr2) overrunSticky <= 1'b1;
    end
  end

  always_ff @(posedge CamPCLK or negedge CamRSTn) begin
    if (!CamRSTn) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (fullNxt) stateNxt = FETCH;
      FETCH:   stateNxt = OUT;
      OUT:     if (accept) stateNxt = lastPix ? IDLE : FETCH;
      default: stateNxt = IDLE;
    endcase
    if (abort || CamVSYNC) stateNxt = IDLE;
  end

  always_ff @(posedge CamPCLK or negedge CamRSTn) begin
    if (!CamRSTn) begin
      rdAddr  <= '0;
      rdData  <= '0;
      nxt     <= 1'b0;
      lineCnt <= '0;
      sofArm  <= 1'b1;
    end else if (CamVSYNC) begin
      rdAddr  <= '0;
      nxt     <= 1'b0;
      lineCnt <= '0;
      sofArm  <= 1'b1;
    end else begin
      if (state == IDLE)           rdAddr <= '0;
      else if (accept && !lastPix) rdAddr <= rdAddr + ONE;
      if (state == FETCH)
        rdData <= nxt ? mem2[rdAddr] : mem1[rdAddr];
      if (accept && lastPix) begin
        nxt     <= ~nxt;
        lineCnt <= lineCnt + ONE;
      end
      if (accept && sofNow) sofArm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_pingpong_reader.sv
// Bench for line_pingpong_reader: vector table plus
// hand-written overrun, VSYNC, saturation and reset sequences.
module tb_line_pingpong_reader;
  localparam int LINE_PIX = 640;
  localparam int ADDR_W   = 10;

  logic CamPCLK = 1'b0;
  logic CamRSTn = 1'b0;
  logic CamVSYNC = 1'b0;
  logic [15:0] pixIn = '0;
  logic writeBuff1 = 1'b0;
  logic writeBuff2 = 1'b0;
  logic buffClear1 = 1'b0;
  logic buffClear2 = 1'b0;
  logic buffSelect = 1'b0;
  logic [ADDR_W-1:0] lineCnt;
  logic overrun, overrunSticky;

  line_pingpong_reader_if rdIf();

  line_pingpong_reader #(
    .LINE_PIX(LINE_PIX),
    .ADDR_W(ADDR_W)
  ) dut (
    .CamPCLK(CamPCLK),
    .CamRSTn(CamRSTn),
    .CamVSYNC(CamVSYNC),
    .pixIn(pixIn),
    .writeBuff1(writeBuff1),
    .writeBuff2(writeBuff2),
    .buffClear1(buffClear1),
    .buffClear2(buffClear2),
    .buffSelect(buffSelect),
    .lineCnt(lineCnt),
    .overrun(overrun),
    .overrunSticky(overrunSticky),
    .rd(rdIf)
  );

  always #5 CamPCLK = ~CamPCLK;

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        sof;
  } exp_t;

  typedef struct {
    int          n;
    logic [15:0] base;
    int          mode;
    bit          waitDone;
    int          expCnt;
    bit          expOvr;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   readyMode = 0;
  logic sofExp = 1'b1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CamPCLK);
    #1;
  endtask

  task automatic pushLine(input int n,
                          input logic [15:0] base,
                          input logic [15:0] step);
    int m;
    exp_t e;
    logic [15:0] v;
    m = (n > LINE_PIX) ? LINE_PIX : n;
    v = base;
    for (int i = 0; i < m; i++) begin
      e.d    = v;
      e.last = (i == m - 1);
      e.sof  = sofExp && (i == 0);
      q.push_back(e);
      v = v + step;
    end
    sofExp = 1'b0;
  endtask

  task automatic writeLine(input bit b, input int n,
                           input logic [15:0] base,
                           input logic [15:0] step,
                           input bit doPush);
    logic [15:0] v;
    if (doPush) pushLine(n, base, step);
    if (b) buffClear2 = 1'b1;
    else   buffClear1 = 1'b1;
    tick();
    buffClear1 = 1'b0;
    buffClear2 = 1'b0;
    v = base;
    for (int i = 0; i < n; i++) begin
      pixIn = v;
      if (b) writeBuff2 = 1'b1;
      else   writeBuff1 = 1'b1;
      tick();
      v = v + step;
    end
    writeBuff1 = 1'b0;
    writeBuff2 = 1'b0;
  endtask

  task automatic commitLine();
    buffSelect = ~buffSelect;
    tick();
  endtask

  task automatic waitDrain(input int bound, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      done = (q.size() == 0) && !rdIf.rdValid;
    end
    chk(name, 32'(done), 1);
  endtask

  task automatic waitValid(input int bound, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      done = rdIf.rdValid;
    end
    chk(name, 32'(done), 1);
  endtask

  task automatic vsyncPulse();
    CamVSYNC = 1'b1;
    buffSelect = 1'b0;
    repeat (3) tick();
    q.delete();
    sofExp = 1'b1;
    CamVSYNC = 1'b0;
    tick();
  endtask

  initial begin
    rdIf.rdReady = 1'b0;
    forever begin
      @(posedge CamPCLK);
      #1;
      case (readyMode)
        0:       rdIf.rdReady = 1'b1;
        1:       rdIf.rdReady = ~rdIf.rdReady;
        default: rdIf.rdReady = 1'b0;
      endcase
    end
  end

  initial begin
    logic prevStall;
    logic [17:0] hold, cur;
    exp_t e;
    prevStall = 1'b0;
    hold = '0;
    forever begin
      @(negedge CamPCLK);
      cur = {rdIf.rdData, rdIf.rdLast, rdIf.rdSof};
      if (rdIf.rdValid && prevStall)
        chk("stall_hold", 32'(cur), 32'(hold));
      if (rdIf.rdValid && rdIf.rdReady) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pix: got %0h expected none",
                   cur);
        end else begin
          e = q.pop_front();
          chk("pix", 32'(cur), 32'({e.d, e.last, e.sof}));
        end
      end
      prevStall = rdIf.rdValid && !rdIf.rdReady;
      hold = cur;
    end
  end

  initial begin
    vec_t vecs[4];
    int lat;
    bit ok, saw;

    vecs[0] = '{5,  16'hA000, 1, 1'b0, 0, 1'b0};
    vecs[1] = '{3,  16'hB000, 1, 1'b1, 3, 1'b0};
    vecs[2] = '{1,  16'hC000, 0, 1'b1, 4, 1'b0};
    vecs[3] = '{16, 16'hD000, 1, 1'b1, 5, 1'b0};

    repeat (3) @(posedge CamPCLK);
    #1;
    chk("rst_data",   32'(rdIf.rdData), 0);
    chk("rst_valid",  32'(rdIf.rdValid), 0);
    chk("rst_last",   32'(rdIf.rdLast), 0);
    chk("rst_sof",    32'(rdIf.rdSof), 0);
    chk("rst_cnt",    32'(lineCnt), 0);
    chk("rst_ovr",    32'(overrun), 0);
    chk("rst_sticky", 32'(overrunSticky), 0);
    @(negedge CamPCLK);
    CamRSTn = 1'b1;
    tick();

    // First line: 3-cycle commit-to-valid latency.
    readyMode = 0;
    writeLine(1'b0, 4, 16'h1111, 16'h1111, 1'b1);
    buffSelect = 1'b1;
    tick();
    chk("lat_edge_k", 32'(rdIf.rdValid), 0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (rdIf.rdValid) lat = i;
    end
    chk("commit_latency", 32'(lat), 3);
    waitDrain(100, "drain_l1");
    chk("cnt_l1", 32'(lineCnt), 1);

    for (int v = 0; v < 4; v++) begin
      readyMode = vecs[v].mode;
      writeLine(buffSelect, vecs[v].n, vecs[v].base,
                16'h0001, 1'b1);
      commitLine();
      if (vecs[v].waitDone) begin
        waitDrain(400, "drain_vec");
        chk("cnt_vec", 32'(lineCnt), 32'(vecs[v].expCnt));
        chk("sticky_vec", 32'(overrunSticky),
            32'(vecs[v].expOvr));
      end
    end

    // Overrun: third line reuses buffer 1 while stalled.
    vsyncPulse();
    readyMode = 2;
    writeLine(1'b0, 4, 16'h1000, 16'h0001, 1'b1);
    commitLine();
    waitValid(10, "ovr_reader_busy");
    writeLine(1'b1, 4, 16'h2000, 16'h0001, 1'b0);
    commitLine();
    repeat (3) tick();
    buffClear1 = 1'b1;
    tick();
    buffClear1 = 1'b0;
    chk("ovr_pulse", 32'(overrun), 1);
    chk("ovr_abort", 32'(rdIf.rdValid), 0);
    tick();
    chk("ovr_once", 32'(overrun), 0);
    chk("ovr_sticky", 32'(overrunSticky), 1);
    chk("ovr_cnt", 32'(lineCnt), 0);
    q.delete();
    sofExp = 1'b1;
    writeLine(1'b0, 4, 16'h3000, 16'h0001, 1'b1);
    pushLine(4, 16'h2000, 16'h0001);
    commitLine();
    readyMode = 0;
    waitDrain(200, "drain_ovr");
    chk("ovr_cnt_after", 32'(lineCnt), 2);
    chk("ovr_sticky_hold", 32'(overrunSticky), 1);

    // VSYNC mid-stream.
    readyMode = 1;
    writeLine(1'b1, 6, 16'h5000, 16'h0001, 1'b0);
    commitLine();
    writeLine(1'b0, 8, 16'h6000, 16'h0001, 1'b1);
    commitLine();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (q.size() <= 5);
    end
    chk("vs_progress", 32'(ok), 1);
    CamVSYNC = 1'b1;
    buffSelect = 1'b0;
    tick();
    chk("vs_valid", 32'(rdIf.rdValid), 0);
    chk("vs_cnt", 32'(lineCnt), 0);
    chk("vs_sticky", 32'(overrunSticky), 0);
    repeat (2) tick();
    q.delete();
    sofExp = 1'b1;
    CamVSYNC = 1'b0;
    tick();

    // Saturation: 700 writes keep 640 pixels.
    readyMode = 0;
    writeLine(1'b0, 700, 16'h7000, 16'h0001, 1'b1);
    commitLine();
    waitDrain(3000, "drain_700");
    chk("cnt_700", 32'(lineCnt), 1);

    // Asynchronous reset mid-line.
    readyMode = 2;
    writeLine(1'b1, 4, 16'h8000, 16'h0001, 1'b1);
    commitLine();
    waitValid(10, "rst_reader_busy");
    writeLine(1'b0, 2, 16'h9000, 16'h0001, 1'b0);
    @(posedge CamPCLK);
    #3;
    CamRSTn = 1'b0;
    #1;
    chk("arst_data",   32'(rdIf.rdData), 0);
    chk("arst_valid",  32'(rdIf.rdValid), 0);
    chk("arst_last",   32'(rdIf.rdLast), 0);
    chk("arst_sof",    32'(rdIf.rdSof), 0);
    chk("arst_cnt",    32'(lineCnt), 0);
    chk("arst_ovr",    32'(overrun), 0);
    chk("arst_sticky", 32'(overrunSticky), 0);
    @(negedge CamPCLK);
    CamRSTn = 1'b1;
    q.delete();
    sofExp = 1'b1;
    tick();
    buffSelect = ~buffSelect;
    readyMode = 0;
    saw = 1'b0;
    repeat (12) begin
      tick();
      saw = saw | rdIf.rdValid;
    end
    chk("zero_len", 32'(saw), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
